proc_sequencer: RTL and testbench

- Program sequencer in front of the simple processor core.
- Fetches instruction words from a synchronous instruction memory and presents them on the core's din.
- Pulses run for each instruction, waits for the core's done, then advances its program counter.
- Turns the single-instruction core into a stand-alone program runner, with a halt opcode and a program-length limit.

---
 rtl/proc_seq_pkg.sv | 31 +++
 rtl/seq_watchdog.sv | 29 ++
 rtl/proc_sequencer.sv | 156 +++++++++++++++
 tb/tb_proc_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/proc_seq_pkg.sv
// proc_seq_pkg: shared definitions for the program sequencer.
//   - opcode field position and opcode constants
//   - sequencer state encoding
//   - opcode extraction helper
package proc_seq_pkg;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        FWAIT    = 3'd2,
        IMM_RD   = 3'd3,
        IMM_WAIT = 3'd4,
        ISSUE    = 3'd5,
        EXEC     = 3'd6,
        FINISH   = 3'd7
    } seq_state_e;

    function automatic logic [2:0] opcode_of(input logic [15:0] w);
        return w[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: counts consecutive EXEC cycles without a core done.
//   clk       system clock
//   reset     synchronous active-high reset
//   clear_i   restart the count (asserted on the cycle before EXEC)
//   en_i      an EXEC cycle in which the core has not signalled done
//   expired_o high during the TIMEOUT-th such cycle
module seq_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;

    // Fires combinationally in the last allowed cycle so the sequencer
    // leaves EXEC exactly after TIMEOUT waiting cycles.
    assign expired_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || clear_i) cnt_q <= '0;
        else if (en_i && !expired_o) cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/proc_sequencer.sv
// proc_sequencer: fetches instruction words from a synchronous instruction
// memory and feeds them one at a time to the simple processor core.
//   clk, reset             clock, synchronous active-high reset
//   start/prog_base/len    begin a run of prog_len words at prog_base
//   imem_addr/rd/data      instruction memory port, 1-cycle read latency
//   din/run/proc_done      core interface (run is a one-cycle pulse)
//   busy/seq_done          status; seq_done pulses once per finished run
//   instr_count            instructions completed in the current/last run
//   error                  sticky watchdog timeout flag
// Build option: SEQ_WATCHDOG_EN adds an EXEC timeout; otherwise error is 0
// and EXEC waits forever for proc_done.
module proc_sequencer
    import proc_seq_pkg::*;
#(
    parameter int AW      = 8,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] prog_base,
    input  logic [AW-1:0] prog_len,
    output logic [AW-1:0] imem_addr,
    output logic          imem_rd,
    input  logic [DW-1:0] imem_data,
    output logic [DW-1:0] din,
    output logic          run,
    input  logic          proc_done,
    output logic          busy,
    output logic          seq_done,
    output logic [AW-1:0] instr_count,
    output logic          error
);
    seq_state_e    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] end_q, end_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] instr_q, instr_d;
    logic [DW-1:0] imm_q, imm_d;
    logic [DW-1:0] din_q, din_d;
    logic          err_q, err_d;
    logic          is_mvi;
    logic          wd_expired;

    assign is_mvi = (opcode_of(instr_q[15:0]) == OP_MVI);

`ifdef SEQ_WATCHDOG_EN
    seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == ISSUE),
        .en_i     ((state_q == EXEC) && !proc_done),
        .expired_o(wd_expired)
    );
`else
    assign wd_expired = 1'b0;
`endif

    // The address is only driven in the read states; elsewhere it holds.
    always_comb begin
        imem_addr = addr_q;
        if (state_q == FETCH)       imem_addr = pc_q;
        else if (state_q == IMM_RD) imem_addr = pc_q + AW'(1);
    end

    assign imem_rd     = (state_q == FETCH) || (state_q == IMM_RD);
    assign run         = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign seq_done    = (state_q == FINISH);
    assign din         = din_q;
    assign instr_count = cnt_q;
    assign error       = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        end_d   = end_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        din_d   = din_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start) begin
                pc_d    = prog_base;
                end_d   = prog_base + prog_len;
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = (prog_len == '0) ? FINISH : FETCH;
            end
            FETCH: state_d = FWAIT;
            FWAIT: begin
                instr_d = imem_data;
                if (opcode_of(imem_data[15:0]) == OP_HALT) begin
                    state_d = FINISH;
                end else if (opcode_of(imem_data[15:0]) == OP_MVI) begin
                    // An mvi whose immediate lies past the program end is dropped.
                    state_d = (AW'(pc_q + AW'(1)) == end_q) ? FINISH : IMM_RD;
                end else begin
                    din_d   = imem_data;
                    state_d = ISSUE;
                end
            end
            IMM_RD: state_d = IMM_WAIT;
            IMM_WAIT: begin
                imm_d   = imem_data;
                din_d   = instr_q;
                state_d = ISSUE;
            end
            ISSUE: begin
                // The core takes the opcode word with run, then the operand.
                din_d   = is_mvi ? imm_q : instr_q;
                state_d = EXEC;
            end
            EXEC: begin
                if (proc_done) begin
                    pc_d    = pc_q + (is_mvi ? AW'(2) : AW'(1));
                    cnt_d   = cnt_q + AW'(1);
                    state_d = (pc_d == end_q) ? FINISH : FETCH;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
            addr_q  <= imem_addr;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
module tb_proc_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  prog_base = '0;
    logic [7:0]  prog_len = '0;
    logic [7:0]  imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data = '0;
    logic [15:0] din;
    logic        run;
    logic        proc_done;
    logic        busy;
    logic        seq_done;
    logic [7:0]  instr_count;
    logic        error;

    proc_sequencer #(.AW(8), .DW(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_base(prog_base),
        .prog_len(prog_len), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .din(din), .run(run), .proc_done(proc_done),
        .busy(busy), .seq_done(seq_done), .instr_count(instr_count),
        .error(error)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory
    logic [15:0] mem [256];
    always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

    // core model: done two cycles after run, unless hung
    int   t = 0;
    logic hang = 1'b0;
    logic stray = 1'b0;
    always @(posedge clk) begin
        if (run) t <= 2;
        else if (t > 0) t <= t - 1;
    end
    assign proc_done = ((t == 1) && !hang) || stray;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // scoreboard: din expected with run, and din expected in the first EXEC cycle
    typedef struct packed { logic [15:0] issue; logic [15:0] exec; } sb_t;
    sb_t         exp_q[$];
    logic        exec_pend = 1'b0;
    logic [15:0] exec_exp = '0;

    always @(negedge clk) begin
        if (exec_pend) begin
            chk("exec_din", {16'h0, din}, {16'h0, exec_exp});
            exec_pend = 1'b0;
        end
        if (run) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                sb_t e;
                e = exp_q.pop_front();
                chk("issue_din", {16'h0, din}, {16'h0, e.issue});
                exec_exp  = e.exec;
                exec_pend = 1'b1;
            end
        end
    end

    // lat = negedges after the sampling edge of start at which seq_done is seen
    task automatic do_run(input logic [7:0] base, input logic [7:0] len,
                          input int inj_start_cyc,
                          output int lat, output int n_run, output int n_rd,
                          output logic busy_after, output logic done_after);
        @(negedge clk);
        prog_base = base; prog_len = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; n_run = 0; n_rd = 0;
        for (int c = 1; c <= 200; c++) begin
            if (run) n_run++;
            if (imem_rd) n_rd++;
            if (seq_done) begin lat = c; break; end
            start = (c == inj_start_cyc);
            @(negedge clk);
        end
        start = 1'b0;
        if (lat < 0) chk("run_timeout", 0, 1);
        @(negedge clk);
        busy_after = busy;
        done_after = seq_done;
    endtask

    int   lat, nr, nd;
    logic ba, da;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h4000;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_run", {31'h0, run}, 0);
        chk("rst_rd", {31'h0, imem_rd}, 0);
        chk("rst_outs", {imem_addr, din, instr_count}, 0);
        chk("rst_flags", {30'h0, seq_done, error}, 0);
        reset = 1'b0;

        // basic: mv, add, sub
        mem[8'h10] = 16'h0040; mem[8'h11] = 16'h4088; mem[8'h12] = 16'h6100;
        exp_q.push_back({16'h0040, 16'h0040});
        exp_q.push_back({16'h4088, 16'h4088});
        exp_q.push_back({16'h6100, 16'h6100});
        do_run(8'h10, 8'd3, 0, lat, nr, nd, ba, da);
        chk("basic_lat", lat, 16);
        chk("basic_runs", nr, 3);
        chk("basic_reads", nd, 3);
        chk("basic_cnt", {24'h0, instr_count}, 3);
        chk("basic_busy_after", {31'h0, ba}, 0);
        chk("basic_done_once", {31'h0, da}, 0);

        // mvi with immediate
        mem[0] = 16'h2000; mem[1] = 16'h00A5;
        exp_q.push_back({16'h2000, 16'h00A5});
        do_run(8'h00, 8'd2, 0, lat, nr, nd, ba, da);
        chk("mvi_lat", lat, 8);
        chk("mvi_runs", nr, 1);
        chk("mvi_reads", nd, 2);
        chk("mvi_cnt", {24'h0, instr_count}, 1);
        chk("mvi_addr_hold", {24'h0, imem_addr}, 1);

        // halt as first word
        mem[0] = 16'hE000;
        do_run(8'h00, 8'd5, 0, lat, nr, nd, ba, da);
        chk("halt_lat", lat, 3);
        chk("halt_runs", nr, 0);
        chk("halt_cnt", {24'h0, instr_count}, 0);

        // zero length: straight to FINISH, no fetch
        do_run(8'h40, 8'd0, 0, lat, nr, nd, ba, da);
        chk("zero_lat", lat, 1);
        chk("zero_reads", nd, 0);
        chk("zero_runs", nr, 0);

        // wrap 0xFF -> 0x00, trailing mvi truncated
        mem[8'hFF] = 16'h4000; mem[0] = 16'h2000;
        exp_q.push_back({16'h4000, 16'h4000});
        do_run(8'hFF, 8'd2, 0, lat, nr, nd, ba, da);
        chk("wrap_lat", lat, 8);
        chk("wrap_runs", nr, 1);
        chk("wrap_cnt", {24'h0, instr_count}, 1);
        chk("wrap_addr", {24'h0, imem_addr}, 0);

        // start pulse during EXEC is ignored
        for (int i = 0; i < 3; i++) exp_q.push_back({mem[8'h10 + i], mem[8'h10 + i]});
        do_run(8'h10, 8'd3, 4, lat, nr, nd, ba, da);
        chk("busy_start_lat", lat, 16);
        chk("busy_start_cnt", {24'h0, instr_count}, 3);
        chk("busy_start_idle", {31'h0, ba}, 0);

        // reset during EXEC aborts
        for (int i = 0; i < 3; i++) exp_q.push_back({mem[8'h10 + i], mem[8'h10 + i]});
        @(negedge clk);
        prog_base = 8'h10; prog_len = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'h0, busy}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        chk("mid_rst_busy", {31'h0, busy}, 0);
        chk("mid_rst_run", {31'h0, run}, 0);
        chk("mid_rst_cnt", {24'h0, instr_count}, 0);
        for (int i = 0; i < 3; i++) exp_q.push_back({mem[8'h10 + i], mem[8'h10 + i]});
        do_run(8'h10, 8'd3, 0, lat, nr, nd, ba, da);
        chk("post_rst_lat", lat, 16);
        chk("post_rst_cnt", {24'h0, instr_count}, 3);

        // stray done while idle has no effect
        @(negedge clk); stray = 1'b1;
        @(negedge clk); stray = 1'b0;
        chk("stray_busy", {31'h0, busy}, 0);
        chk("stray_cnt", {24'h0, instr_count}, 3);

`ifdef SEQ_WATCHDOG_EN
        hang = 1'b1;
        mem[8'h20] = 16'h4000;
        exp_q.push_back({16'h4000, 16'h4000});
        do_run(8'h20, 8'd1, 0, lat, nr, nd, ba, da);
        chk("wd_lat", lat, 20);
        chk("wd_runs", nr, 1);
        chk("wd_cnt", {24'h0, instr_count}, 0);
        chk("wd_err_sticky", {31'h0, error}, 1);
        hang = 1'b0;
        exp_q.push_back({16'h4000, 16'h4000});
        do_run(8'h20, 8'd1, 0, lat, nr, nd, ba, da);
        chk("wd_clr_lat", lat, 6);
        chk("wd_err_clr", {31'h0, error}, 0);
`else
        chk("err_tied", {31'h0, error}, 0);
`endif

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
